// File: rtl/alarm_tone_seq_if.sv
// Control/status bundle between the alarm-clock FSM, the tone sequencer and
// the piezo frequency counter.
interface alarm_tone_seq_if;
  logic        alarm_on;
  logic        snooze;
  logic [14:0] note_per;
  logic        clr_freq;
  logic        tone_en;
  logic        busy;
  logic [2:0]  note_idx;

  // Alarm-clock side: requests playback and observes the sequencer.
  modport master (
    output alarm_on,
    output snooze,
    input  note_per,
    input  clr_freq,
    input  tone_en,
    input  busy,
    input  note_idx
  );

  // Sequencer side.
  modport slave (
    input  alarm_on,
    input  snooze,
    output note_per,
    output clr_freq,
    output tone_en,
    output busy,
    output note_idx
  );
endinterface

// File: rtl/alarm_tone_seq.sv
// Alarm melody sequencer: loops an 8-note melody while the alarm is active,
// with silent gaps between notes, a longer pause after the last note and a
// snooze hold-off. Outputs are decoded purely from the state registers.
module alarm_tone_seq #(
  parameter int NOTE_DUR   = 12_500_000,
  parameter int GAP_DUR    = 2_500_000,
  parameter int LOOP_PAUSE = 25_000_000,
  parameter int SNOOZE_DUR = 250_000_000,
  parameter int TW         = 28
) (
  input  logic             clk,
  input  logic             rst,
  alarm_tone_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NOTE   = 3'd1,
    GAP    = 3'd2,
    PAUSE  = 3'd3,
    SNOOZE = 3'd4
  } state_t;

  localparam logic [TW-1:0] NOTE_LAST   = TW'(NOTE_DUR - 1);
  localparam logic [TW-1:0] GAP_LAST    = TW'(GAP_DUR - 1);
  localparam logic [TW-1:0] PAUSE_LAST  = TW'(LOOP_PAUSE - 1);
  localparam logic [TW-1:0] SNOOZE_LAST = TW'(SNOOZE_DUR - 1);

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    idx, idx_n;

  // Melody table: counter period for each of the eight notes.
  function automatic logic [14:0] note_rom(input logic [2:0] i);
    case (i)
      3'd0:    return 15'd23888;
      3'd1:    return 15'd21282;
      3'd2:    return 15'd18960;
      3'd3:    return 15'd17896;
      3'd4:    return 15'd15943;
      3'd5:    return 15'd14204;
      3'd6:    return 15'd12654;
      default: return 15'd11944;
    endcase
  endfunction

  // State, timer and note index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      idx   <= idx_n;
    end
  end

  // Next-state logic: alarm drop beats snooze, snooze beats timer expiry.
  always_comb begin
    state_n = state;
    timer_n = timer + 1'b1;
    idx_n   = idx;
    if (!bus.alarm_on) begin
      state_n = IDLE;
      timer_n = '0;
      idx_n   = '0;
    end else if (bus.snooze && (state == NOTE || state == GAP || state == PAUSE)) begin
      state_n = SNOOZE;
      timer_n = '0;
      idx_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = NOTE;
          timer_n = '0;
          idx_n   = '0;
        end
        NOTE: begin
          if (timer == NOTE_LAST) begin
            state_n = (idx == 3'd7) ? PAUSE : GAP;
            timer_n = '0;
          end
        end
        GAP: begin
          if (timer == GAP_LAST) begin
            state_n = NOTE;
            timer_n = '0;
            idx_n   = idx + 3'd1;
          end
        end
        PAUSE: begin
          if (timer == PAUSE_LAST) begin
            state_n = NOTE;
            timer_n = '0;
            idx_n   = '0;
          end
        end
        SNOOZE: begin
          if (timer == SNOOZE_LAST) begin
            state_n = NOTE;
            timer_n = '0;
            idx_n   = '0;
          end
        end
        default: begin
          state_n = IDLE;
          timer_n = '0;
          idx_n   = '0;
        end
      endcase
    end
  end

  // Moore output decode; the counter is cleared at the start of every note
  // and held clear whenever the piezo is silent.
  always_comb begin
    bus.note_per = '0;
    bus.tone_en  = 1'b0;
    bus.clr_freq = 1'b1;
    bus.busy     = (state != IDLE);
    bus.note_idx = idx;
    if (state == NOTE) begin
      bus.note_per = note_rom(idx);
      bus.tone_en  = 1'b1;
      bus.clr_freq = (timer == '0);
    end
  end

endmodule

// File: tb/tb_alarm_tone_seq.sv
// Directed bench for alarm_tone_seq with shortened note/gap/pause/snooze times.
module tb_alarm_tone_seq;
  logic clk = 1'b0;
  logic rst;

  alarm_tone_seq_if bus();

  alarm_tone_seq #(
    .NOTE_DUR  (4),
    .GAP_DUR   (2),
    .LOOP_PAUSE(3),
    .SNOOZE_DUR(5),
    .TW        (28)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [14:0] rom [8] = '{15'd23888, 15'd21282, 15'd18960, 15'd17896,
                           15'd15943, 15'd14204, 15'd12654, 15'd11944};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (per,clr,ten,busy,idx packed)", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [14:0] per, input logic clr,
                                       input logic ten, input logic busy, input logic [2:0] idx);
    return {11'd0, per, clr, ten, busy, idx};
  endfunction

  task automatic step(input string tag, input logic [31:0] exp);
    @(posedge clk);
    #1;
    check_eq(tag, {11'd0, bus.note_per, bus.clr_freq, bus.tone_en, bus.busy, bus.note_idx}, exp);
  endtask

  task automatic play_note(input string tag, input int n);
    for (int t = 0; t < 4; t++)
      step(tag, pack(rom[n], (t == 0), 1'b1, 1'b1, 3'(n)));
  endtask

  task automatic silent(input string tag, input int count, input int idx, input logic busy);
    for (int c = 0; c < count; c++)
      step(tag, pack(15'd0, 1'b1, 1'b0, busy, 3'(idx)));
  endtask

  initial begin
    rst          = 1'b1;
    bus.alarm_on = 1'b1;
    bus.snooze   = 1'b0;

    // Reset held two cycles with alarm requested.
    step("rst0", pack(15'd0, 1'b1, 1'b0, 1'b0, 3'd0));
    step("rst1", pack(15'd0, 1'b1, 1'b0, 1'b0, 3'd0));
    rst = 1'b0;

    // Full melody loop followed by the wrap back to note 0.
    for (int n = 0; n < 8; n++) begin
      play_note("loop_note", n);
      if (n < 7) silent("loop_gap", 2, n, 1'b1);
    end
    silent("loop_pause", 3, 7, 1'b1);
    play_note("wrap_note0", 0);
    silent("gap0", 2, 0, 1'b1);
    play_note("note1", 1);
    silent("gap1", 2, 1, 1'b1);
    play_note("note2", 2);
    silent("gap2", 2, 2, 1'b1);

    // Snooze in the second cycle of note 3; a second press is ignored.
    step("n3_t0", pack(rom[3], 1'b1, 1'b1, 1'b1, 3'd3));
    step("n3_t1", pack(rom[3], 1'b0, 1'b1, 1'b1, 3'd3));
    bus.snooze = 1'b1;
    silent("snz_t0", 1, 0, 1'b1);
    bus.snooze = 1'b0;
    silent("snz_t1", 1, 0, 1'b1);
    bus.snooze = 1'b1;
    silent("snz_t2", 1, 0, 1'b1);
    bus.snooze = 1'b0;
    silent("snz_t34", 2, 0, 1'b1);
    play_note("after_snz", 0);

    // Alarm dropped during a gap.
    silent("gap_before_stop", 1, 0, 1'b1);
    bus.alarm_on = 1'b0;
    step("stop_idle", pack(15'd0, 1'b1, 1'b0, 1'b0, 3'd0));
    bus.alarm_on = 1'b1;
    step("restart_t0", pack(rom[0], 1'b1, 1'b1, 1'b1, 3'd0));
    step("restart_t1", pack(rom[0], 1'b0, 1'b1, 1'b1, 3'd0));

    // Reset in the middle of a note.
    rst = 1'b1;
    step("midrst_idle", pack(15'd0, 1'b1, 1'b0, 1'b0, 3'd0));
    rst = 1'b0;
    step("postrst_t0", pack(rom[0], 1'b1, 1'b1, 1'b1, 3'd0));

    // Snooze together with alarm drop: alarm drop wins.
    bus.snooze   = 1'b1;
    bus.alarm_on = 1'b0;
    step("snz_and_off", pack(15'd0, 1'b1, 1'b0, 1'b0, 3'd0));
    bus.snooze   = 1'b0;
    bus.alarm_on = 1'b1;

    // Snooze on the note expiry edge: snooze wins over the gap.
    play_note("pre_expiry", 0);
    bus.snooze = 1'b1;
    silent("expiry_snz_t0", 1, 0, 1'b1);
    bus.snooze = 1'b0;
    silent("expiry_snz_rest", 4, 0, 1'b1);
    step("expiry_snz_done", pack(rom[0], 1'b1, 1'b1, 1'b1, 3'd0));

    bus.alarm_on = 1'b0;
    step("final_idle", pack(15'd0, 1'b1, 1'b0, 1'b0, 3'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
